// File: rtl/vga_timing_monitor.sv
// rtl/vga_timing_monitor.sv - VGA receive-side timing checker with probe-pixel capture
// Measures line/frame totals and sync widths, flags frame-to-frame lock, samples one pixel.
module vga_timing_monitor #(
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int TIMEOUT_BITS    = 22
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hSyncIn,
  input  logic        vSyncIn,
  input  logic        redIn,
  input  logic        greenIn,
  input  logic        blueIn,
  input  logic        intenseIn,
  input  logic [11:0] probeX,
  input  logic [10:0] probeY,
  output logic [11:0] hTotal,
  output logic [11:0] hSyncWidth,
  output logic [10:0] vTotal,
  output logic [10:0] vSyncWidth,
  output logic        locked,
  output logic        frameDone,
  output logic [3:0]  probeColor,
  output logic        probeValid
);

  typedef enum logic [1:0] {IDLE, MEASURE, CHECK} state_t;

  localparam logic POL = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic                    h_s, h_p, v_s, v_p;
  logic [3:0]              rgbi;
  logic [11:0]             h_count, hs_count, ref_h;
  logic [10:0]             v_count, vs_count, ref_v;
  logic                    probe_done;
  logic [TIMEOUT_BITS-1:0] wd_count;
  state_t                  state;

  logic        h_edge, h_trail, v_edge, v_trail, probe_hit;
  logic [11:0] h_total_nxt, h_total_now;
  logic [10:0] v_total_nxt;

  assign h_edge    = h_s & ~h_p;
  assign h_trail   = ~h_s & h_p;
  assign v_edge    = v_s & ~v_p;
  assign v_trail   = ~v_s & v_p;
  assign h_total_nxt = (h_count == 12'hFFF) ? 12'hFFF : h_count + 12'd1;
  assign h_total_now = h_edge ? h_total_nxt : hTotal;
  // A coincident hsync edge closes the last line of the ending frame.
  assign v_total_nxt = (h_edge && v_count != 11'h7FF) ? v_count + 11'd1 : v_count;
  assign probe_hit   = !probe_done && h_count == probeX && v_count == probeY;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_s  <= 1'b0;
      h_p  <= 1'b0;
      v_s  <= 1'b0;
      v_p  <= 1'b0;
      rgbi <= 4'd0;
    end else begin
      h_s  <= hSyncIn ^ POL;
      h_p  <= h_s;
      v_s  <= vSyncIn ^ POL;
      v_p  <= v_s;
      rgbi <= {redIn, greenIn, blueIn, intenseIn};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_count    <= 12'd0;
      hs_count   <= 12'd0;
      hTotal     <= 12'd0;
      hSyncWidth <= 12'd0;
      v_count    <= 11'd0;
      vs_count   <= 11'd0;
      vTotal     <= 11'd0;
      vSyncWidth <= 11'd0;
      probe_done <= 1'b0;
      probeColor <= 4'd0;
      probeValid <= 1'b0;
    end else begin
      if (h_edge) begin
        hTotal  <= h_total_nxt;
        h_count <= 12'd0;
      end else if (h_count != 12'hFFF) begin
        h_count <= h_count + 12'd1;
      end

      if (h_edge) hs_count <= 12'd1;
      else if (h_s && hs_count != 12'hFFF) hs_count <= hs_count + 12'd1;
      if (h_trail) hSyncWidth <= hs_count;

      if (v_edge) begin
        vTotal  <= v_total_nxt;
        v_count <= 11'd0;
      end else if (h_edge && v_count != 11'h7FF) begin
        v_count <= v_count + 11'd1;
      end

      if (v_edge) vs_count <= {10'd0, h_edge};
      else if (h_edge && v_s && vs_count != 11'h7FF) vs_count <= vs_count + 11'd1;
      if (v_trail) vSyncWidth <= vs_count;

      probeValid <= probe_hit;
      if (probe_hit) probeColor <= rgbi;
      probe_done <= v_edge ? 1'b0 : (probe_done | probe_hit);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      locked    <= 1'b0;
      frameDone <= 1'b0;
      ref_h     <= 12'd0;
      ref_v     <= 11'd0;
      wd_count  <= '0;
    end else begin
      frameDone <= 1'b0;
      if (v_edge) begin
        wd_count <= '0;
        case (state)
          IDLE: state <= MEASURE;
          MEASURE: begin
            ref_h     <= h_total_now;
            ref_v     <= v_total_nxt;
            frameDone <= 1'b1;
            state     <= CHECK;
          end
          default: begin
            frameDone <= 1'b1;
            locked    <= (h_total_now == ref_h) && (v_total_nxt == ref_v);
            ref_h     <= h_total_now;
            ref_v     <= v_total_nxt;
          end
        endcase
      end else if (wd_count == '1) begin
        wd_count <= '0;
        state    <= IDLE;
        locked   <= 1'b0;
      end else begin
        wd_count <= wd_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb/tb_vga_timing_monitor.sv - directed self-checking bench for vga_timing_monitor
// A second instance with an 8-bit watchdog covers the no-vsync timeout.
module tb_vga_timing_monitor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        hsync = 1'b1, vsync = 1'b1;
  logic        red = 1'b0, green = 1'b0, blue = 1'b0, intense = 1'b0;
  logic [11:0] px = 12'd4000;
  logic [10:0] py = 11'd2000;
  int          cx = -10, cy = -10;
  logic [3:0]  pcol = 4'b1011;

  logic [11:0] h_total, hs_width, w_h_total, w_hs_width;
  logic [10:0] v_total, vs_width, w_v_total, w_vs_width;
  logic        locked, frame_done, probe_valid, w_locked, w_frame_done, w_probe_valid;
  logic [3:0]  probe_color, w_probe_color;

  int n_cmp = 0, n_fail = 0;
  int fd_cnt = 0, pv_cnt = 0, wfd_cnt = 0;
  int snap;

  vga_timing_monitor dut (
    .clk(clk), .reset(rst), .hSyncIn(hsync), .vSyncIn(vsync),
    .redIn(red), .greenIn(green), .blueIn(blue), .intenseIn(intense),
    .probeX(px), .probeY(py), .hTotal(h_total), .hSyncWidth(hs_width),
    .vTotal(v_total), .vSyncWidth(vs_width), .locked(locked), .frameDone(frame_done),
    .probeColor(probe_color), .probeValid(probe_valid)
  );

  vga_timing_monitor #(.SYNC_ACTIVE_LOW(1'b1), .TIMEOUT_BITS(8)) dut_wd (
    .clk(clk), .reset(rst), .hSyncIn(hsync), .vSyncIn(vsync),
    .redIn(red), .greenIn(green), .blueIn(blue), .intenseIn(intense),
    .probeX(px), .probeY(py), .hTotal(w_h_total), .hSyncWidth(w_hs_width),
    .vTotal(w_v_total), .vSyncWidth(w_vs_width), .locked(w_locked), .frameDone(w_frame_done),
    .probeColor(w_probe_color), .probeValid(w_probe_valid)
  );

  always @(posedge clk) begin
    if (frame_done) fd_cnt++;
    if (probe_valid) pv_cnt++;
    if (w_frame_done) wfd_cnt++;
  end

  // Colour is placed one column after (cx,cy): the monitor's hCount lags the pin column by one.
  task automatic run_frame(input int ht, input int hsw, input int vt, input int vsw, input bit ven);
    for (int y = 0; y < vt; y++) begin
      for (int x = 0; x < ht; x++) begin
        @(negedge clk);
        hsync = ~(x < hsw);
        vsync = ~(ven && y < vsw);
        {red, green, blue, intense} = (x == cx + 1 && y == cy) ? pcol : 4'b0000;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    hsync = 1'b1; vsync = 1'b1; {red, green, blue, intense} = 4'b0000;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if ({h_total, hs_width, v_total, vs_width, locked, frame_done, probe_color, probe_valid} !== 53'd0) begin
      n_fail++; $display("FAIL reset_outputs got %h want 0", {h_total, hs_width, v_total, vs_width, locked, frame_done, probe_color, probe_valid}); end
    n_cmp++; if ({w_h_total, w_v_total, w_locked, w_frame_done} !== 25'd0) begin
      n_fail++; $display("FAIL reset_outputs_wd got %h want 0", {w_h_total, w_v_total, w_locked, w_frame_done}); end
    rst = 1'b0;
  endtask

  task automatic test_synthetic();
    do_reset();
    snap = fd_cnt;
    run_frame(20, 3, 10, 2, 1'b1);
    run_frame(20, 3, 10, 2, 1'b1);
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL syn_lock_early got %b want 0", locked); end
    run_frame(20, 3, 10, 2, 1'b1);
    n_cmp++; if (h_total !== 12'd20) begin n_fail++; $display("FAIL syn_htotal got %0d want 20", h_total); end
    n_cmp++; if (hs_width !== 12'd3) begin n_fail++; $display("FAIL syn_hsync got %0d want 3", hs_width); end
    n_cmp++; if (v_total !== 11'd10) begin n_fail++; $display("FAIL syn_vtotal got %0d want 10", v_total); end
    n_cmp++; if (vs_width !== 11'd2) begin n_fail++; $display("FAIL syn_vsync got %0d want 2", vs_width); end
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL syn_lock got %b want 1", locked); end
    n_cmp++; if (fd_cnt - snap !== 2) begin n_fail++; $display("FAIL syn_framedone3 got %0d want 2", fd_cnt - snap); end
    run_frame(20, 3, 10, 2, 1'b1);
    n_cmp++; if (fd_cnt - snap !== 3) begin n_fail++; $display("FAIL syn_framedone4 got %0d want 3", fd_cnt - snap); end
  endtask

  task automatic test_vtotal_change();
    run_frame(20, 3, 11, 2, 1'b1);
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL chg_still_locked got %b want 1", locked); end
    run_frame(20, 3, 11, 2, 1'b1);
    n_cmp++; if (v_total !== 11'd11) begin n_fail++; $display("FAIL chg_vtotal got %0d want 11", v_total); end
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL chg_unlock got %b want 0", locked); end
    run_frame(20, 3, 11, 2, 1'b1);
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL chg_relock got %b want 1", locked); end
  endtask

  task automatic test_probe();
    px = 12'd5; py = 11'd3; cx = 5; cy = 3;
    do_reset();
    snap = pv_cnt;
    repeat (3) run_frame(20, 3, 10, 2, 1'b1);
    n_cmp++; if (probe_color !== 4'b1011) begin n_fail++; $display("FAIL probe_color got %b want 1011", probe_color); end
    n_cmp++; if (pv_cnt - snap !== 3) begin n_fail++; $display("FAIL probe_valid_count got %0d want 3", pv_cnt - snap); end
    px = 12'd4;
    run_frame(20, 3, 10, 2, 1'b1);
    n_cmp++; if (probe_color !== 4'b0000) begin n_fail++; $display("FAIL probe_neighbour got %b want 0000", probe_color); end
    px = 12'd4000; py = 11'd2000; cx = -10; cy = -10;
  endtask

  task automatic test_h800();
    do_reset();
    repeat (3) run_frame(800, 96, 6, 2, 1'b1);
    n_cmp++; if (h_total !== 12'd800) begin n_fail++; $display("FAIL h800_htotal got %0d want 800", h_total); end
    n_cmp++; if (hs_width !== 12'd96) begin n_fail++; $display("FAIL h800_hsync got %0d want 96", hs_width); end
    n_cmp++; if (v_total !== 11'd6) begin n_fail++; $display("FAIL h800_vtotal got %0d want 6", v_total); end
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL h800_lock got %b want 1", locked); end
  endtask

  task automatic test_v525();
    do_reset();
    repeat (3) run_frame(16, 3, 525, 2, 1'b1);
    n_cmp++; if (v_total !== 11'd525) begin n_fail++; $display("FAIL v525_vtotal got %0d want 525", v_total); end
    n_cmp++; if (vs_width !== 11'd2) begin n_fail++; $display("FAIL v525_vsync got %0d want 2", vs_width); end
    n_cmp++; if (h_total !== 12'd16) begin n_fail++; $display("FAIL v525_htotal got %0d want 16", h_total); end
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL v525_lock got %b want 1", locked); end
  endtask

  task automatic test_watchdog();
    do_reset();
    repeat (3) run_frame(20, 3, 10, 2, 1'b1);
    n_cmp++; if (w_locked !== 1'b1) begin n_fail++; $display("FAIL wd_lock_before got %b want 1", w_locked); end
    repeat (2) run_frame(20, 3, 10, 2, 1'b0);
    n_cmp++; if (w_locked !== 1'b0) begin n_fail++; $display("FAIL wd_timeout_unlock got %b want 0", w_locked); end
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL wd_long_timeout_kept got %b want 1", locked); end
    snap = wfd_cnt;
    repeat (2) run_frame(20, 3, 10, 2, 1'b1);
    n_cmp++; if (wfd_cnt - snap !== 1) begin n_fail++; $display("FAIL wd_idle_framedone got %0d want 1", wfd_cnt - snap); end
    run_frame(20, 3, 10, 2, 1'b1);
    n_cmp++; if (w_locked !== 1'b1) begin n_fail++; $display("FAIL wd_relock got %b want 1", w_locked); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    repeat (3) run_frame(20, 3, 10, 2, 1'b1);
    run_frame(20, 3, 4, 2, 1'b1);
    rst = 1'b1;
    #1;
    n_cmp++; if ({h_total, hs_width, v_total, vs_width, locked, frame_done, probe_color, probe_valid} !== 53'd0) begin
      n_fail++; $display("FAIL mid_reset_outputs got %h want 0", {h_total, hs_width, v_total, vs_width, locked, frame_done, probe_color, probe_valid}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) run_frame(20, 3, 10, 2, 1'b1);
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL mid_lock_early got %b want 0", locked); end
    run_frame(20, 3, 10, 2, 1'b1);
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL mid_relock got %b want 1", locked); end
    n_cmp++; if (v_total !== 11'd10) begin n_fail++; $display("FAIL mid_vtotal got %0d want 10", v_total); end
  endtask

  initial begin
    test_reset();
    test_synthetic();
    test_vtotal_change();
    test_probe();
    test_h800();
    test_v525();
    test_watchdog();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
